// File: rtl/ex_stage.sv
// ex_stage: integer execute stage.
//
// Purpose
//   Computes single-cycle logic, shift and HI/LO move results, and runs a
//   32-iteration shift-add multiplier (MULT/MULTU) that writes HI/LO.
//   While the multiplier is busy the stage stalls its upstream producer.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   valid_i, aluop_i, alusel_i    decoded instruction and its result class
//   reg1_i, reg2_i                source operands (shift amount in reg1_i[4:0])
//   wd_i, wreg_i                  destination register address / write request
//   stall_o                       input not consumed this cycle
//   ex_wreg_o/ex_wd_o/ex_wdata_o  combinational forwarding to decode
//   valid_o/wreg_o/wd_o/wdata_o   registered result into the memory stage
//   hi_o, lo_o                    architectural HI/LO registers

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic        stall_o,
    output logic        ex_wreg_o,
    output logic [4:0]  ex_wd_o,
    output logic [31:0] ex_wdata_o,
    output logic        valid_o,
    output logic        wreg_o,
    output logic [4:0]  wd_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Result classes
    localparam logic [2:0] SelNop   = 3'b000;
    localparam logic [2:0] SelLogic = 3'b001;
    localparam logic [2:0] SelShift = 3'b010;
    localparam logic [2:0] SelMove  = 3'b011;

    // Operation codes
    localparam logic [7:0] OpAnd   = 8'h24;
    localparam logic [7:0] OpOr    = 8'h25;
    localparam logic [7:0] OpXor   = 8'h26;
    localparam logic [7:0] OpNor   = 8'h27;
    localparam logic [7:0] OpSll   = 8'h7C;
    localparam logic [7:0] OpSrl   = 8'h02;
    localparam logic [7:0] OpSra   = 8'h03;
    localparam logic [7:0] OpMfhi  = 8'h10;
    localparam logic [7:0] OpMflo  = 8'h12;
    localparam logic [7:0] OpMult  = 8'h18;
    localparam logic [7:0] OpMultu = 8'h19;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg;
    logic [4:0]  r_cnt;

    logic        w_idle;
    logic        w_take;
    logic        w_mul_op;
    logic        w_mul_signed;
    logic        w_mul_start;
    logic        w_mul_done;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [63:0] w_acc_next;
    logic [63:0] w_product;
    logic [31:0] w_result;
    logic        w_known;

    assign w_idle       = (r_state == StIdle);
    assign w_take       = w_idle && valid_i;
    assign w_mul_op     = (aluop_i == OpMult) || (aluop_i == OpMultu);
    assign w_mul_signed = (aluop_i == OpMult);
    assign w_mul_start  = w_take && w_mul_op;
    // r_cnt counts completed BUSY edges; the edge seen with 31 is the 32nd.
    assign w_mul_done   = (r_state == StBusy) && (r_cnt == 5'd31);

    // Signed multiply runs on magnitudes; the sign is reapplied at the end.
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign w_mag1 = (w_mul_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
    assign w_mag2 = (w_mul_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_product  = r_neg ? (64'd0 - w_acc_next) : w_acc_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_mul_start) w_state_next = StBusy;
            StBusy:  if (w_mul_done)  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall_o = 1'b0;
        if (!rst && (r_state == StBusy)) begin
            stall_o = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle result
    // ------------------------------------------------------------------
    always_comb begin
        w_result = 32'd0;
        w_known  = 1'b0;
        case (alusel_i)
            SelLogic: begin
                w_known = 1'b1;
                case (aluop_i)
                    OpAnd:   w_result = reg1_i & reg2_i;
                    OpOr:    w_result = reg1_i | reg2_i;
                    OpXor:   w_result = reg1_i ^ reg2_i;
                    OpNor:   w_result = ~(reg1_i | reg2_i);
                    default: w_known  = 1'b0;
                endcase
            end
            SelShift: begin
                w_known = 1'b1;
                case (aluop_i)
                    OpSll:   w_result = reg2_i << reg1_i[4:0];
                    OpSrl:   w_result = reg2_i >> reg1_i[4:0];
                    OpSra:   w_result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
                    default: w_known  = 1'b0;
                endcase
            end
            SelMove: begin
                w_known = 1'b1;
                case (aluop_i)
                    OpMfhi:  w_result = r_hi;
                    OpMflo:  w_result = r_lo;
                    default: w_known  = 1'b0;
                endcase
            end
            SelNop:  w_known = 1'b0;
            default: w_known = 1'b0;
        endcase
    end

    // Forwarding path: only a consumable, recognised, writing op forwards.
    assign ex_wd_o    = wd_i;
    assign ex_wdata_o = w_result;
    assign ex_wreg_o  = !rst && w_take && w_known && wreg_i;

    // ------------------------------------------------------------------
    // Registered result into the memory stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            wd_o    <= 5'd0;
            wdata_o <= 32'd0;
        end else if (w_idle) begin
            valid_o <= valid_i;
            wreg_o  <= valid_i && w_known && wreg_i;
            wd_o    <= wd_i;
            wdata_o <= w_result;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_neg    <= 1'b0;
            r_cnt    <= 5'd0;
        end else if (w_mul_start) begin
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= w_mul_signed && (reg1_i[31] ^ reg2_i[31]);
            r_cnt    <= 5'd0;
        end else if (r_state == StBusy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[62:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
            if (w_mul_done) begin
                r_hi <= w_product[63:32];
                r_lo <= w_product[31:0];
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam logic [2:0] SelNop   = 3'b000;
    localparam logic [2:0] SelLogic = 3'b001;
    localparam logic [2:0] SelShift = 3'b010;
    localparam logic [2:0] SelMove  = 3'b011;

    localparam logic [7:0] OpAnd   = 8'h24;
    localparam logic [7:0] OpOr    = 8'h25;
    localparam logic [7:0] OpXor   = 8'h26;
    localparam logic [7:0] OpNor   = 8'h27;
    localparam logic [7:0] OpSll   = 8'h7C;
    localparam logic [7:0] OpSrl   = 8'h02;
    localparam logic [7:0] OpSra   = 8'h03;
    localparam logic [7:0] OpMfhi  = 8'h10;
    localparam logic [7:0] OpMflo  = 8'h12;
    localparam logic [7:0] OpMult  = 8'h18;
    localparam logic [7:0] OpMultu = 8'h19;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        stall_o;
    logic        ex_wreg_o;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic        valid_o;
    logic        wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    int n;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .stall_o    (stall_o),
        .ex_wreg_o  (ex_wreg_o),
        .ex_wd_o    (ex_wd_o),
        .ex_wdata_o (ex_wdata_o),
        .valid_o    (valid_o),
        .wreg_o     (wreg_o),
        .wd_o       (wd_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        valid_i  = v;
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles until stall_o drops, bounded at 40.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (stall_o && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, OpOr, SelLogic, 32'h1, 32'h2, 5'd3, 1'b1);
        check("rst_stall", stall_o, 0);
        check("rst_ex_wreg", ex_wreg_o, 0);
        tick();
        tick();
        check("rst_valid_o", valid_o, 0);
        check("rst_wreg_o", wreg_o, 0);
        check("rst_wd_o", wd_o, 0);
        check("rst_wdata_o", wdata_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        rst = 1'b0;

        // OR with forwarding
        drive(1'b1, OpOr, SelLogic, 32'h0000FF00, 32'h00F000F0, 5'd5, 1'b1);
        check("or_ex_wdata", ex_wdata_o, 32'h00F0FFF0);
        check("or_ex_wreg", ex_wreg_o, 1);
        check("or_ex_wd", ex_wd_o, 5);
        tick();
        check("or_wdata", wdata_o, 32'h00F0FFF0);
        check("or_wd", wd_o, 5);
        check("or_wreg", wreg_o, 1);
        check("or_valid", valid_o, 1);

        drive(1'b1, OpSra, SelShift, 32'd4, 32'h80000000, 5'd1, 1'b1);
        tick();
        check("sra", wdata_o, 32'hF8000000);
        drive(1'b1, OpSrl, SelShift, 32'd4, 32'h80000000, 5'd1, 1'b1);
        tick();
        check("srl", wdata_o, 32'h08000000);
        drive(1'b1, OpSll, SelShift, 32'h00000024, 32'h0000000F, 5'd1, 1'b1);
        tick();
        check("sll_amt_low5", wdata_o, 32'h000000F0);
        drive(1'b1, OpNor, SelLogic, 32'h0F0F0000, 32'h000000FF, 5'd2, 1'b1);
        tick();
        check("nor", wdata_o, 32'hF0F0FF00);
        drive(1'b1, OpXor, SelLogic, 32'hFF00FF00, 32'h0FF00FF0, 5'd2, 1'b1);
        tick();
        check("xor", wdata_o, 32'hF0F0F0F0);
        drive(1'b1, OpAnd, SelLogic, 32'hFF00FF00, 32'h0FF00FF0, 5'd2, 1'b1);
        tick();
        check("and", wdata_o, 32'h0F000F00);

        // Bubble and unrecognised op
        drive(1'b0, OpOr, SelLogic, 32'h1, 32'h2, 5'd4, 1'b1);
        check("bubble_ex_wreg", ex_wreg_o, 0);
        tick();
        check("bubble_valid", valid_o, 0);
        check("bubble_wreg", wreg_o, 0);
        drive(1'b1, 8'h55, SelLogic, 32'h1, 32'h2, 5'd4, 1'b1);
        tick();
        check("unk_valid", valid_o, 1);
        check("unk_wreg", wreg_o, 0);
        check("unk_wdata", wdata_o, 0);

        // MULT -1 x 1 followed by held MFLO
        drive(1'b1, OpMult, SelNop, 32'hFFFFFFFF, 32'h00000001, 5'd9, 1'b1);
        tick();
        check("mult_start_valid", valid_o, 1);
        check("mult_start_wreg", wreg_o, 0);
        check("mult_start_wdata", wdata_o, 0);
        check("mult_start_stall", stall_o, 1);
        drive(1'b1, OpMflo, SelMove, 32'h0, 32'h0, 5'd7, 1'b1);
        check("busy_ex_wreg", ex_wreg_o, 0);
        tick();
        check("busy_valid", valid_o, 0);
        check("busy_wreg", wreg_o, 0);
        wait_idle(n);
        check("mult_stall_len", n + 1, 32);
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFFF);
        check("mflo_ex_wdata", ex_wdata_o, 32'hFFFFFFFF);
        tick();
        check("mflo_wdata", wdata_o, 32'hFFFFFFFF);
        check("mflo_wreg", wreg_o, 1);
        check("mflo_wd", wd_o, 7);

        drive(1'b1, OpMultu, SelNop, 32'hFFFFFFFF, 32'h00000001, 5'd0, 1'b0);
        tick();
        drive(1'b0, OpNor, SelNop, 32'h0, 32'h0, 5'd0, 1'b0);
        wait_idle(n);
        check("multu_stall_len", n, 32);
        check("multu_hi", hi_o, 32'h0);
        check("multu_lo", lo_o, 32'hFFFFFFFF);

        drive(1'b1, OpMult, SelNop, 32'h80000000, 32'h80000000, 5'd0, 1'b0);
        tick();
        drive(1'b0, OpNor, SelNop, 32'h0, 32'h0, 5'd0, 1'b0);
        wait_idle(n);
        check("mult_min_hi", hi_o, 32'h40000000);
        check("mult_min_lo", lo_o, 32'h0);

        drive(1'b1, OpMultu, SelNop, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        tick();
        drive(1'b0, OpNor, SelNop, 32'h0, 32'h0, 5'd0, 1'b0);
        wait_idle(n);
        check("multu_max_hi", hi_o, 32'hFFFFFFFE);
        check("multu_max_lo", lo_o, 32'h00000001);
        drive(1'b1, OpMfhi, SelMove, 32'h0, 32'h0, 5'd8, 1'b1);
        tick();
        check("mfhi_wdata", wdata_o, 32'hFFFFFFFE);

        // Back-to-back: MULT 3 x -2 then held MULTU 5 x 7
        drive(1'b1, OpMult, SelNop, 32'd3, 32'hFFFFFFFE, 5'd0, 1'b0);
        tick();
        drive(1'b1, OpMultu, SelNop, 32'd5, 32'd7, 5'd0, 1'b0);
        wait_idle(n);
        check("b2b_first_len", n, 32);
        check("b2b_first_hi", hi_o, 32'hFFFFFFFF);
        check("b2b_first_lo", lo_o, 32'hFFFFFFFA);
        tick();
        check("b2b_second_stall", stall_o, 1);
        drive(1'b0, OpNor, SelNop, 32'h0, 32'h0, 5'd0, 1'b0);
        wait_idle(n);
        check("b2b_second_len", n, 32);
        check("b2b_second_hi", hi_o, 32'h0);
        check("b2b_second_lo", lo_o, 32'd35);

        // Reset in BUSY cycle 10
        drive(1'b1, OpMult, SelNop, 32'd7, 32'd9, 5'd0, 1'b0);
        tick();
        drive(1'b0, OpNor, SelNop, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_stall", stall_o, 1);
        rst = 1'b1;
        #1;
        check("rst_comb_stall", stall_o, 0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_stall", stall_o, 0);
        check("midrst_hi", hi_o, 0);
        check("midrst_lo", lo_o, 0);
        check("midrst_valid", valid_o, 0);
        for (int i = 0; i < 40; i++) tick();
        check("discard_hi", hi_o, 0);
        check("discard_lo", lo_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 valid_i  in  1  decode-stage instruction present.
REQ-004 aluop_i  in  8  operation code (defines.vh *_OP).
REQ-005 alusel_i  in  3  result class: NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
REQ-006 reg1_i  in  32  source operand 1; for shifts, amount = reg1_i[4:0].
REQ-007 reg2_i  in  32  source operand 2; for shifts, value shifted.
REQ-008 wd_i  in  5  destination register address.
REQ-009 wreg_i  in  1  destination write request.
REQ-010 stall_o  out  1  high = input not consumed this cycle; upstream holds its outputs.
REQ-011 ex_wreg_o, ex_wd_o, ex_wdata_o  out  1/5/32  combinational current-cycle result, forwarded to decode's ex_* ports.
REQ-012 valid_o, wreg_o, wd_o, wdata_o  out  1/1/5/32  registered result into the memory stage.
REQ-013 hi_o, lo_o  out  32/32  architectural HI/LO registers.

Function
REQ-014 Ops: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, MFHI 0x10, MFLO 0x12, MULT 0x18 (signed), MULTU 0x19 (unsigned), NOP 0x00.
REQ-015 FSM states: IDLE, BUSY; stall_o = (state==BUSY).
REQ-016 Input consumed on each rising edge in IDLE; no input is consumed in BUSY.
REQ-017 Single-cycle op, consumed in IDLE: registered outputs update on the same edge with the computed result; wd_o=wd_i; valid_o=valid_i.
REQ-018 Logic ops: bitwise on reg1_i, reg2_i; NOR = ~(a|b).
REQ-019 SLL/SRL: reg2_i shifted by reg1_i[4:0], zero-filled; SRA: sign-filled.
REQ-020 MFHI/MFLO: wdata = current hi_o/lo_o.
REQ-021 alusel NOP or unrecognised aluop: wdata 0, wreg_o forced 0.
REQ-022 MULT/MULTU consumed in IDLE (edge N):
- latch operand magnitudes, sign flag and counter=0; go BUSY.
- on edge N: valid_o=1, wreg_o=0, wdata_o=0.
REQ-023 BUSY: one shift-add iteration per edge over a 64-bit accumulator; counter increments per edge.
REQ-024 Completion on the 32nd BUSY edge (N+32):
- {hi,lo} = product, two's-complement negated for signed MULT with exactly one negative operand.
- state returns to IDLE.
- stall_o is therefore high for exactly 32 cycles.
REQ-025 BUSY: valid_o=0, wreg_o=0 each edge; ex_wreg_o=0.
REQ-026 ex_* forwarding outputs:
- equal the values REQ-017..021 would register this cycle when IDLE and valid_i=1.
- otherwise ex_wreg_o=0.
REQ-027 valid_i=0 in IDLE: bubble; valid_o=0, wreg_o=0, no FSM change.
REQ-028 Instruction following MULT is held upstream and consumed on the first IDLE edge; an MFHI/MFLO there reads the new product.
REQ-029 Back-to-back MULT: the second MULT is consumed at edge N+33 and overwrites HI/LO at edge N+65.
REQ-030 No other op modifies HI/LO.

Reset
REQ-031 rst=1 at an edge, including mid-BUSY:
- state to IDLE, counter 0.
- hi_o, lo_o, wdata_o = 0.
- valid_o, wreg_o = 0; wd_o = 0.
- the in-flight multiply is discarded.
REQ-032 While rst=1: stall_o=0 and ex_wreg_o=0.

Verification
REQ-033 OR, reg1=0x0000FF00, reg2=0x00F000F0, wd=5, wreg=1 -> next edge: wdata_o=0x00F0FFF0, wd_o=5, wreg_o=1; ex_wdata_o shows the same value in the input cycle.
REQ-034 SRA, reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000; SRL same operands -> 0x08000000.
REQ-035 MULT 0xFFFFFFFF x 0x00000001 -> stall_o high 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFF; MULTU same operands -> HI=0, LO=0xFFFFFFFF.
REQ-036 MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 MULT then held MFLO (wd=7) -> MFLO consumed on the first IDLE edge; wdata_o=new LO, wreg_o=1.
REQ-038 rst asserted at BUSY cycle 10 -> next edge: state IDLE, hi_o=lo_o=0, stall_o=0, valid_o=0.
